// File: rtl/combo_pkg.sv
// Shared types and key constants for the combination-lock datapath.
// Used by the attempt guard and the safe core.
package combo_pkg;

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    FLUSH   = 2'd1,
    LOCKOUT = 2'd2
  } guard_state_t;

  localparam logic [3:0] KEY_CLEAR = 4'hF;
  localparam logic [3:0] KEY_ENTER = 4'hE;

endpackage

// File: rtl/attempt_guard_if.sv
// Key-event and check-result bundle between capture, guard and safe core.
// master drives key/check events; slave is the guard.
interface attempt_guard_if;

  logic       key_valid;
  logic [3:0] key_code;
  logic       check_done;
  logic       check_pass;
  logic       fwd_valid;
  logic [3:0] fwd_code;
  logic       lockout;
  logic [1:0] fail_count;
  logic [3:0] remain_sec;

  modport master (
    output key_valid,
    output key_code,
    output check_done,
    output check_pass,
    input  fwd_valid,
    input  fwd_code,
    input  lockout,
    input  fail_count,
    input  remain_sec
  );

  modport slave (
    input  key_valid,
    input  key_code,
    input  check_done,
    input  check_pass,
    output fwd_valid,
    output fwd_code,
    output lockout,
    output fail_count,
    output remain_sec
  );

endinterface

// File: rtl/attempt_guard_tick_gen.sv
// Free-running seconds divider for the lockout timer.
// tick is high on the last cycle of each TICK_CYCLES period.
module tick_gen #(
  parameter int TICK_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int W = $clog2(TICK_CYCLES);
  localparam logic [W-1:0] LAST = W'(TICK_CYCLES - 1);

  logic [W-1:0] count;

  assign tick = enable && (count == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/attempt_guard.sv
// Brute-force guard: forwards keys, counts failed checks, and
// locks the keypad out for LOCKOUT_SEC seconds after MAX_FAILS.
module attempt_guard
  import combo_pkg::*;
#(
  parameter int MAX_FAILS   = 3,
  parameter int LOCKOUT_SEC = 10,
  parameter int TICK_CYCLES = 50_000_000
) (
  input logic           MAX10_CLK1_50,
  input logic           reset,
  attempt_guard_if.slave bus
);

  localparam logic [1:0] FAIL_LAST = 2'(MAX_FAILS - 1);
  localparam logic [1:0] FAIL_MAX  = 2'(MAX_FAILS);
  localparam logic [3:0] SEC_INIT  = 4'(LOCKOUT_SEC);

  guard_state_t state, state_n;
  logic         fv_q, fv_n;
  logic [3:0]   fc_q, fc_n;
  logic         lock_q, lock_n;
  logic [1:0]   fail_q, fail_n;
  logic [3:0]   rem_q, rem_n;
  logic         tick;

  tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick (
    .clk    (MAX10_CLK1_50),
    .reset  (reset),
    .enable (state == LOCKOUT),
    .clear  (state != LOCKOUT),
    .tick   (tick)
  );

  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      state  <= ARMED;
      fv_q   <= 1'b0;
      fc_q   <= 4'h0;
      lock_q <= 1'b0;
      fail_q <= 2'd0;
      rem_q  <= 4'd0;
    end else begin
      state  <= state_n;
      fv_q   <= fv_n;
      fc_q   <= fc_n;
      lock_q <= lock_n;
      fail_q <= fail_n;
      rem_q  <= rem_n;
    end
  end

  always_comb begin
    state_n = state;
    fv_n    = 1'b0;
    fc_n    = fc_q;
    fail_n  = fail_q;
    rem_n   = rem_q;
    unique case (state)
      ARMED: begin
        if (bus.key_valid) begin
          fv_n = 1'b1;
          fc_n = bus.key_code;
        end
        if (bus.check_done) begin
          if (bus.check_pass) begin
            fail_n = 2'd0;
          end else if (fail_q >= FAIL_LAST) begin
            // Synthetic clear wipes any partial entry in the core
            state_n = FLUSH;
            fail_n  = FAIL_MAX;
            fv_n    = 1'b1;
            fc_n    = KEY_CLEAR;
          end else begin
            fail_n = fail_q + 2'd1;
          end
        end
      end
      FLUSH: begin
        state_n = LOCKOUT;
        rem_n   = SEC_INIT;
      end
      LOCKOUT: begin
        if (tick) begin
          if (rem_q <= 4'd1) begin
            state_n = ARMED;
            rem_n   = 4'd0;
            fail_n  = 2'd0;
          end else begin
            rem_n = rem_q - 4'd1;
          end
        end
      end
      default: begin
        state_n = ARMED;
      end
    endcase
    lock_n = (state_n != ARMED);
  end

  assign bus.fwd_valid  = fv_q;
  assign bus.fwd_code   = fc_q;
  assign bus.lockout    = lock_q;
  assign bus.fail_count = fail_q;
  assign bus.remain_sec = rem_q;

endmodule

// File: tb/tb_attempt_guard.sv
// Directed and randomized checks of attempt_guard against a
// cycle-elapsed reference model of the lockout behaviour.
module tb_attempt_guard;
  import combo_pkg::*;

  localparam int MF = 3;
  localparam int LS = 3;
  localparam int TC = 10;

  logic clk = 1'b0;
  logic reset;
  attempt_guard_if bus();

  always #5 clk = ~clk;

  attempt_guard #(
    .MAX_FAILS   (MF),
    .LOCKOUT_SEC (LS),
    .TICK_CYCLES (TC)
  ) dut (
    .MAX10_CLK1_50 (clk),
    .reset         (reset),
    .bus           (bus)
  );

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  task automatic chk(string name, int got, int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // m_e: cycles elapsed since the lockout trigger edge, -1 when armed
  int m_fc = 0;
  int m_e = -1;
  int m_fv = 0;
  int m_code = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_fc = 0;
      m_e = -1;
      m_fv = 0;
      m_code = 0;
    end else if (m_e >= 0) begin
      m_fv = 0;
      m_e++;
      if (m_e > LS * TC) begin
        m_e = -1;
        m_fc = 0;
      end
    end else begin
      m_fv = int'(bus.key_valid);
      if (bus.key_valid) m_code = int'(bus.key_code);
      if (bus.check_done) begin
        if (bus.check_pass) m_fc = 0;
        else if (m_fc == MF - 1) begin
          m_fc = MF;
          m_e = 0;
          m_fv = 1;
          m_code = 15;
        end else m_fc++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_fwd_valid", int'(bus.fwd_valid), m_fv);
      if (m_fv != 0) chk("m_fwd_code", int'(bus.fwd_code), m_code);
      chk("m_lockout", int'(bus.lockout), (m_e >= 0) ? 1 : 0);
      chk("m_fail_count", int'(bus.fail_count), m_fc);
      chk("m_remain_sec", int'(bus.remain_sec),
          (m_e >= 1) ? LS - (m_e - 1) / TC : 0);
    end
  end

  task automatic cyc(bit r, bit kv, logic [3:0] kc, bit cd, bit cp);
    reset = r;
    bus.key_valid = kv;
    bus.key_code = kc;
    bus.check_done = cd;
    bus.check_pass = cp;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_rand_lock();
    cyc(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_fwd_valid"}, int'(bus.fwd_valid), 0);
    chk({tag, "_fwd_code"}, int'(bus.fwd_code), 0);
    chk({tag, "_lockout"}, int'(bus.lockout), 0);
    chk({tag, "_fail_count"}, int'(bus.fail_count), 0);
    chk({tag, "_remain_sec"}, int'(bus.remain_sec), 0);
  endtask

  initial begin
    cyc(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 4'h3, 1'b1, 1'b0);
    chk_on = 1'b1;
    chk_zero("rst");

    cyc(1'b0, 1'b1, 4'h5, 1'b0, 1'b0);
    chk("key5_valid", int'(bus.fwd_valid), 1);
    chk("key5_code", int'(bus.fwd_code), 5);
    cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    chk("key5_single", int'(bus.fwd_valid), 0);

    cyc(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    chk("fail1", int'(bus.fail_count), 1);
    cyc(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    chk("fail2", int'(bus.fail_count), 2);
    cyc(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
    chk("pass_clr", int'(bus.fail_count), 0);
    chk("pass_nolock", int'(bus.lockout), 0);

    cyc(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 4'h7, 1'b1, 1'b0);
    chk("flush_valid", int'(bus.fwd_valid), 1);
    chk("flush_code", int'(bus.fwd_code), 15);
    chk("flush_lock", int'(bus.lockout), 1);
    chk("flush_fc", int'(bus.fail_count), 3);
    for (int e = 1; e <= 31; e++) begin
      cyc_rand_lock();
      chk("lock_nofwd", int'(bus.fwd_valid), 0);
      if (e <= 30) begin
        chk("lock_fc", int'(bus.fail_count), 3);
        chk("lock_hi", int'(bus.lockout), 1);
      end
      case (e)
        1, 10: chk("rem3", int'(bus.remain_sec), 3);
        11, 20: chk("rem2", int'(bus.remain_sec), 2);
        21, 30: chk("rem1", int'(bus.remain_sec), 1);
        31: begin
          chk("end_rem", int'(bus.remain_sec), 0);
          chk("end_lock", int'(bus.lockout), 0);
          chk("end_fc", int'(bus.fail_count), 0);
        end
        default: ;
      endcase
    end
    cyc(1'b0, 1'b1, 4'h9, 1'b0, 1'b0);
    chk("post_valid", int'(bus.fwd_valid), 1);
    chk("post_code", int'(bus.fwd_code), 9);

    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 11; i++) cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    chk("pre_rst_rem", int'(bus.remain_sec), 2);
    cyc(1'b1, 1'b1, 4'h3, 1'b1, 1'b0);
    chk_zero("midlock_rst");
    cyc(1'b0, 1'b1, 4'h4, 1'b0, 1'b0);
    chk("rst_key_valid", int'(bus.fwd_valid), 1);
    chk("rst_key_code", int'(bus.fwd_code), 4);

    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    chk("flush2_lock", int'(bus.lockout), 1);
    cyc(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    chk("flush_rst_valid", int'(bus.fwd_valid), 0);
    chk("flush_rst_lock", int'(bus.lockout), 0);

    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 199) == 0),
          1'($urandom_range(0, 2) == 0),
          4'($urandom_range(0, 15)),
          1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 2) == 0));
    end

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/attempt_guard.md
ATTEMPT_GUARD -- requirements
Module: attempt_guard

Interface
REQ-001 The block SHALL have parameter MAX_FAILS, default 3, meaning consecutive failed checks that trigger lockout (1..3).
REQ-002 The block SHALL have parameter LOCKOUT_SEC, default 10, meaning lockout duration in seconds (1..15).
REQ-003 The block SHALL have parameter TICK_CYCLES, default 50_000_000, meaning clock cycles per second tick (>=2).
REQ-004 The block SHALL have port MAX10_CLK1_50  in  1  the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 The block SHALL have port key_valid  in  1  one-cycle key-event pulse from the capture stage.
REQ-007 The block SHALL have port key_code  in  4  key value, qualified by key_valid (F = clear, E = enter/data).
REQ-008 The block SHALL have port check_done  in  1  one-cycle pulse from the safe core when an enter-compare completes in locked state.
REQ-009 The block SHALL have port check_pass  in  1  compare result, qualified by check_done.
REQ-010 The block SHALL have port fwd_valid  out  1  registered key-event pulse to the safe core.
REQ-011 The block SHALL have port fwd_code  out  4  registered key value, qualified by fwd_valid.
REQ-012 The block SHALL have port lockout  out  1  high while in FLUSH or LOCKOUT.
REQ-013 The block SHALL have port fail_count  out  2  current consecutive-failure count.
REQ-014 The block SHALL have port remain_sec  out  4  seconds of lockout remaining; 0 outside LOCKOUT.

Function
REQ-015 The FSM SHALL have states ARMED, FLUSH, LOCKOUT; all outputs SHALL be registered.
REQ-016 In ARMED, key_valid SHALL produce fwd_valid=1, fwd_code=key_code exactly one cycle later; otherwise fwd_valid=0.
REQ-017 In ARMED, check_done with check_pass=1 SHALL clear fail_count to 0 on the next edge.
REQ-018 In ARMED, check_done with check_pass=0 and fail_count<MAX_FAILS-1 SHALL increment fail_count by 1.
REQ-019 In ARMED, check_done with check_pass=0 and fail_count=MAX_FAILS-1 SHALL transition to FLUSH, setting fail_count=MAX_FAILS.
REQ-020 On the FLUSH transition edge, fwd_valid SHALL be 1 with fwd_code=4'hF (synthetic clear) and any coincident key_valid SHALL be dropped.
REQ-021 FLUSH SHALL last one cycle, then LOCKOUT with remain_sec=LOCKOUT_SEC and the tick counter at 0.
REQ-022 In FLUSH and LOCKOUT, all key_valid and check_done pulses SHALL be ignored (fwd_valid=0, no count change).
REQ-023 In LOCKOUT, the tick counter SHALL count 0..TICK_CYCLES-1 and wrap; each wrap SHALL decrement remain_sec by 1.
REQ-024 A wrap with remain_sec=1 SHALL set remain_sec=0, fail_count=0, and return to ARMED on the same edge.
REQ-025 A key_valid in the first ARMED cycle after lockout SHALL be forwarded normally.
REQ-026 Coincident key_valid and non-lockout check_done in ARMED SHALL both take effect (key forwarded, count updated).
REQ-027 fail_count SHALL never exceed MAX_FAILS, and remain_sec SHALL never underflow.

Reset
REQ-028 Reset SHALL force state=ARMED, fwd_valid=0, fwd_code=0, lockout=0, fail_count=0, remain_sec=0, tick counter=0.
REQ-029 Reset SHALL take priority over all inputs, including mid-LOCKOUT and FLUSH, with no synthetic clear emitted.

Structure
REQ-030 The guard_state_t enum (ARMED, FLUSH, LOCKOUT) and key constants KEY_CLEAR=4'hF, KEY_ENTER=4'hE SHALL live in shared package combo_pkg.
REQ-031 The tick counter SHALL be a sub-module, tick_gen (enable, clear, tick pulse output), parameterised by TICK_CYCLES.

Verification (MAX_FAILS=3, LOCKOUT_SEC=3, TICK_CYCLES=10)
REQ-032 The bench SHALL cover key_valid with code 5 in ARMED -> fwd_valid with code 5 exactly one cycle later, single pulse.
REQ-033 The bench SHALL cover two failed checks then one pass -> fail_count 1, 2, then 0; lockout stays 0.
REQ-034 The bench SHALL cover three failed checks, with key 7 coincident on the third -> next cycle fwd_code=F, key 7 absent, lockout=1; remain_sec 3,2,1,0 at 10-cycle spacing; ARMED after 30 LOCKOUT cycles.
REQ-035 The bench SHALL cover keys and check_done during LOCKOUT -> no fwd_valid and fail_count held at 3.
REQ-036 The bench SHALL cover reset asserted at remain_sec=2 -> next cycle all outputs 0 and ARMED; the following key is forwarded.
